// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared CPU definitions used by the ALU arbiter slice:
//   - data / opcode widths (WordDataBus = 32, AluOpBus = 4)
//   - ALU_OP_* opcode encodings
//   - arbiter FSM state encoding and requester-id width
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

   localparam int WORD_W   = 32;  // WordDataBus
   localparam int ALUOP_W  = 4;   // AluOpBus
   localparam int REQ_ID_W = 1;   // two requesters

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [ALUOP_W-1:0]  alu_op_t;
   typedef logic [REQ_ID_W-1:0] req_id_t;

   // ALU opcodes; any other encoding passes in_0 through
   localparam alu_op_t ALU_OP_NOP  = 4'h0;
   localparam alu_op_t ALU_OP_AND  = 4'h1;
   localparam alu_op_t ALU_OP_OR   = 4'h2;
   localparam alu_op_t ALU_OP_XOR  = 4'h3;
   localparam alu_op_t ALU_OP_ADDS = 4'h4;  // signed add, sets overflow
   localparam alu_op_t ALU_OP_ADDU = 4'h5;
   localparam alu_op_t ALU_OP_SUBS = 4'h6;  // signed subtract, sets overflow
   localparam alu_op_t ALU_OP_SUBU = 4'h7;
   localparam alu_op_t ALU_OP_SHRL = 4'h8;
   localparam alu_op_t ALU_OP_SHLL = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational CPU ALU shared by the arbiter.
// Ports:
//   in_0, in_1 : operands (WordDataBus)
//   op         : ALU_OP_* opcode
//   out        : result, wraps modulo 2^32; shifts use in_1[4:0]
//   of         : signed overflow, only for ALU_OP_ADDS / ALU_OP_SUBS
// -----------------------------------------------------------------------------
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic [WORD_W-1:0]  in_0,
   input  logic [WORD_W-1:0]  in_1,
   input  logic [ALUOP_W-1:0] op,
   output logic [WORD_W-1:0]  out,
   output logic               of
);

   logic [WORD_W-1:0] sum;
   logic [WORD_W-1:0] diff;

   assign sum  = in_0 + in_1;
   assign diff = in_0 - in_1;

   // NOTE: every output gets a default before the case so no path leaves it
   // unassigned; otherwise a latch is inferred.
   always_comb begin
      out = in_0;
      of  = 1'b0;
      case (op)
         ALU_OP_AND:  out = in_0 & in_1;
         ALU_OP_OR:   out = in_0 | in_1;
         ALU_OP_XOR:  out = in_0 ^ in_1;
         ALU_OP_ADDS: begin
            out = sum;
            // operands of equal sign producing a result of the other sign
            of  = (in_0[WORD_W-1] == in_1[WORD_W-1]) &&
                  (sum[WORD_W-1]  != in_0[WORD_W-1]);
         end
         ALU_OP_ADDU: out = sum;
         ALU_OP_SUBS: begin
            out = diff;
            of  = (in_0[WORD_W-1] != in_1[WORD_W-1]) &&
                  (diff[WORD_W-1] != in_0[WORD_W-1]);
         end
         ALU_OP_SUBU: out = diff;
         ALU_OP_SHRL: out = in_0 >> in_1[4:0];
         ALU_OP_SHLL: out = in_0 << in_1[4:0];
         default:     out = in_0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters. Each transaction walks
// IDLE -> EXEC -> RESP: accept in IDLE, compute in EXEC (one cycle),
// hold the registered result in RESP until the owner takes it.
// Accept at cycle T gives rspN_valid at T+2.
//
// Ports (N = 0,1):
//   clk, reset                 : clock, synchronous active-high reset
//   reqN_valid / reqN_ready    : request handshake (ready only in IDLE)
//   reqN_in_0, reqN_in_1       : operands
//   reqN_op                    : ALU_OP_* opcode
//   rspN_valid / rspN_ready    : response handshake
//   rspN_out, rspN_of          : registered result / signed overflow,
//                                0 on the port that does not own the result
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   : round robin on simultaneous valids (last-grant register)
//   undefined : fixed priority, requester 0 wins
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               reset,

   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WORD_W-1:0]  req0_in_0,
   input  logic [WORD_W-1:0]  req0_in_1,
   input  logic [ALUOP_W-1:0] req0_op,

   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WORD_W-1:0]  req1_in_0,
   input  logic [WORD_W-1:0]  req1_in_1,
   input  logic [ALUOP_W-1:0] req1_op,

   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic [WORD_W-1:0]  rsp0_out,
   output logic               rsp0_of,

   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [WORD_W-1:0]  rsp1_out,
   output logic               rsp1_of
);

   arb_state_e state, state_nxt;

   logic    grant0, grant1;
   logic    accept;

   word_t   lat_in_0, lat_in_1;
   alu_op_t lat_op;
   req_id_t lat_id;

   word_t   alu_out;
   logic    alu_of;
   word_t   res_out;
   logic    res_of;

`ifdef ALU_ARB_RR_EN
   req_id_t last_grant;
`endif

   // ---------------------------------------------------------------- grant
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
         // the requester not granted last time wins
         grant0 = last_grant[0];
         grant1 = ~last_grant[0];
`else
         grant0 = 1'b1;
`endif
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   // ------------------------------------------------------------------ FSM
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            // grants already imply the matching valid
            req0_ready = grant0 & ~reset;
            req1_ready = grant1 & ~reset;
            if (req0_ready || req1_ready) state_nxt = ST_EXEC;
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            rsp0_valid = (lat_id == 1'b0);
            rsp1_valid = (lat_id == 1'b1);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign accept = req0_ready | req1_ready;

   // ------------------------------------------------------------- datapath
   // NOTE: the operand latches are only consumed after an accept has loaded
   // them, so they carry no reset; only architecturally visible state does.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_in_0 <= req1_ready ? req1_in_0 : req0_in_0;
         lat_in_1 <= req1_ready ? req1_in_1 : req0_in_1;
         lat_op   <= req1_ready ? req1_op   : req0_op;
         lat_id   <= req1_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_out <= '0;
         res_of  <= 1'b0;
      end else if (state == ST_EXEC) begin
         res_out <= alu_out;
         res_of  <= alu_of;
      end
   end

`ifdef ALU_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset)       last_grant <= 1'b1;  // requester 0 wins first
      else if (accept) last_grant <= req1_ready;
   end
`endif

   alu_arbiter_alu alu (
      .in_0 (lat_in_0),
      .in_1 (lat_in_1),
      .op   (lat_op),
      .out  (alu_out),
      .of   (alu_of)
   );

   // only the owning port shows the result, the other stays at zero
   assign rsp0_out = rsp0_valid ? res_out : '0;
   assign rsp0_of  = rsp0_valid & res_of;
   assign rsp1_out = rsp1_valid ? res_out : '0;
   assign rsp1_of  = rsp1_valid & res_of;

endmodule
